// File: rtl/tbcm_packet_mux.sv
// Packet mux: LRG-arbitrated sharing of one valid/ready channel among REQUESTS sources, grant held to last beat.
// Latency 1 cycle (registered output stage); one idle upstream cycle after a multi-beat packet ends.
// Backpressure: o_ready follows the output slot state (!o_valid || i_ready); TBCM_PACKET_MUX_GRANT_COUNT_EN adds o_grant_count.
module tbcm_packet_mux #(
    parameter  int REQUESTS   = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(REQUESTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTS-1:0]            i_valid,
    output logic [REQUESTS-1:0]            o_ready,
    input  logic [REQUESTS*DATA_WIDTH-1:0] i_data,
    input  logic [REQUESTS-1:0]            i_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_last,
    output logic [IDX_W-1:0]               o_grant_index,
    output logic                           o_busy
`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
    ,
    output logic [REQUESTS*16-1:0]         o_grant_count
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rank_q [REQUESTS];
    logic                    gap_q;
    logic                    slot_free;
    logic                    win_vld;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        best_rank;
    logic [IDX_W-1:0]        sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    accept;
    logic                    first_accept;

    assign slot_free    = !o_valid || i_ready;
    assign sel_idx      = (state_q == LOCKED) ? o_grant_index : win_idx;
    assign accept       = |(i_valid & o_ready);
    assign first_accept = accept && (state_q == IDLE);

    // rank 0 is the highest priority; ranks always form a permutation
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        best_rank = '1;
        for (int k = 0; k < REQUESTS; k++) begin
            if (i_valid[k] && (!win_vld || rank_q[k] < best_rank)) begin
                win_vld   = 1'b1;
                win_idx   = IDX_W'(k);
                best_rank = rank_q[k];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < REQUESTS; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_last = i_last[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !sel_last) state_d = LOCKED;
            LOCKED:  if (accept && sel_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // gap_q keeps the first IDLE cycle after a locked packet free of grants
    always_comb begin
        o_ready = '0;
        case (state_q)
            IDLE:    if (win_vld && !gap_q) o_ready[win_idx] = slot_free;
            LOCKED:  o_ready[o_grant_index] = slot_free;
            default: o_ready = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q         <= 1'b0;
            o_busy        <= 1'b0;
            o_grant_index <= '0;
            for (int k = 0; k < REQUESTS; k++) begin
                rank_q[k] <= IDX_W'(k);
            end
        end else begin
            gap_q  <= (state_q == LOCKED) && accept && sel_last;
            o_busy <= (state_d == LOCKED);
            if (first_accept) begin
                o_grant_index <= win_idx;
                for (int k = 0; k < REQUESTS; k++) begin
                    if (IDX_W'(k) == win_idx) begin
                        rank_q[k] <= IDX_W'(REQUESTS - 1);
                    end else if (rank_q[k] > rank_q[win_idx]) begin
                        rank_q[k] <= rank_q[k] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_data  <= sel_data;
            o_last  <= sel_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
    logic [15:0] grant_cnt_q [REQUESTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REQUESTS; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else if (first_accept) begin
            for (int k = 0; k < REQUESTS; k++) begin
                if (IDX_W'(k) == win_idx && grant_cnt_q[k] != 16'hFFFF) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        o_grant_count = '0;
        for (int k = 0; k < REQUESTS; k++) begin
            o_grant_count[k*16 +: 16] = grant_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_tbcm_packet_mux.sv
// Randomized bench for tbcm_packet_mux against a queue-based LRG reference model.
module tb_tbcm_packet_mux;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int N_CYC  = 3000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    o_ready;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_last;
    logic            o_valid;
    logic            i_ready;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [1:0]      o_grant_index;
    logic            o_busy;
`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
    logic [N*16-1:0] o_grant_count;
`endif

    always #5 clk = ~clk;

    tbcm_packet_mux #(.REQUESTS(N), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_last        (i_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_grant_index (o_grant_index),
        .o_busy        (o_busy)
`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
        ,
        .o_grant_count (o_grant_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // source-side state: each source holds its beat until it is accepted
    bit            s_vld  [N];
    logic [DW-1:0] s_data [N];
    bit            s_last [N];
    int            s_left [N];

    // reference model: LRG order as a list, head is highest priority
    int            lrg [$];
    int            owner;
    bit            gap;
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_last;
    int            m_gidx;
    bit            m_busy;
    int            m_cnt [N];
    int            acc;

    task automatic model_reset();
        lrg = {0, 1, 2, 3};
        owner = -1;
        gap = 0;
        m_valid = 0;
        m_data = '0;
        m_last = 0;
        m_gidx = 0;
        m_busy = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            i_valid[k]            = s_vld[k];
            i_data[k*DW +: DW]    = s_data[k];
            i_last[k]             = s_last[k];
        end
    endtask

    task automatic check_registered();
        check("o_valid", 64'(o_valid), 64'(m_valid));
        check("o_data", 64'(o_data), 64'(m_data));
        check("o_last", 64'(o_last), 64'(m_last));
        check("o_grant_index", 64'(o_grant_index), 64'(m_gidx));
        check("o_busy", 64'(o_busy), 64'(m_busy));
`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
        begin
            logic [63:0] exp_cnt;
            for (int k = 0; k < N; k++) exp_cnt[k*16 +: 16] = 16'(m_cnt[k]);
            check("o_grant_count", 64'(o_grant_count), exp_cnt);
        end
`endif
    endtask

    task automatic model_step();
        logic [N-1:0] er;
        bit           slot;
        int           win;
        bit           ngap;
        slot = !m_valid || i_ready;
        er = '0;
        if (owner >= 0) begin
            er[owner] = slot;
        end else if (!gap) begin
            win = -1;
            foreach (lrg[j]) if (win < 0 && i_valid[lrg[j]]) win = lrg[j];
            if (win >= 0) er[win] = slot;
        end
        check("o_ready", 64'(o_ready), 64'(er));
        acc = -1;
        for (int k = 0; k < N; k++) if (er[k] && i_valid[k]) acc = k;
        ngap = 0;
        if (acc >= 0) begin
            m_valid = 1;
            m_data  = s_data[acc];
            m_last  = s_last[acc];
            if (owner < 0) begin
                m_gidx = acc;
                foreach (lrg[j]) if (lrg[j] == acc) begin lrg.delete(j); break; end
                lrg.push_back(acc);
                if (m_cnt[acc] < 16'hFFFF) m_cnt[acc]++;
                if (!s_last[acc]) begin
                    owner  = acc;
                    m_busy = 1;
                end
            end else if (s_last[acc]) begin
                owner  = -1;
                m_busy = 0;
                ngap   = 1;
            end
        end else if (i_ready) begin
            m_valid = 0;
        end
        gap = ngap;
    endtask

    initial begin
        bit rst_cycle;
        bit rst_done1;
        bit rst_done2;
        rst       = 1'b1;
        i_ready   = 1'b0;
        rst_done1 = 0;
        rst_done2 = 0;
        for (int k = 0; k < N; k++) begin
            s_vld[k] = 0; s_data[k] = '0; s_last[k] = 0; s_left[k] = 0;
        end
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_busy", 64'(o_busy), 64'd0);
        check("rst_o_grant_index", 64'(o_grant_index), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd0);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            rst_cycle = rst;
            acc = -1;
            if (!rst_cycle) begin
                check_registered();
                model_step();
            end
            @(posedge clk);
            #1;
            if (rst_cycle) begin
                rst = 1'b0;
                model_reset();
                for (int k = 0; k < N; k++) begin
                    s_vld[k] = 0; s_left[k] = 0;
                end
            end else if (acc >= 0) begin
                s_vld[acc] = 0;
                s_left[acc]--;
            end
            if (!rst_cycle && m_busy && ((!rst_done1 && cyc >= 400) || (!rst_done2 && cyc >= 1500))) begin
                if (!rst_done1) rst_done1 = 1; else rst_done2 = 1;
                rst = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (!s_vld[k] && $urandom_range(0, 99) < 60) begin
                    if (s_left[k] <= 0) s_left[k] = $urandom_range(1, 4);
                    s_vld[k]  = 1;
                    s_data[k] = $urandom;
                    s_last[k] = (s_left[k] == 1);
                end
            end
            i_ready = ($urandom_range(0, 99) < 70);
            drive_inputs();
        end
        check("mid_packet_resets_seen", 64'({rst_done1, rst_done2}), 64'b11);

`ifdef TBCM_PACKET_MUX_GRANT_COUNT_EN
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            s_vld[k] = (k == 3); s_data[k] = 32'h3; s_last[k] = 1;
        end
        i_ready = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("grant_count_src3_sat", 64'(o_grant_count[3*16 +: 16]), 64'hFFFF);
        check("grant_count_others", 64'(o_grant_count[0 +: 48]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
